hex_digit_scanner: RTL and testbench
====================================

# hex_digit_scanner

Time-multiplexed driver for a four-digit, common-anode seven-segment display. It sits directly downstream of the 16-bit hex-digits PIO in the SoC: it takes that PIO's `out_port` value and decimal-point enables, and produces active-low segment and anode drives. The input is captured once per frame into a shadow register so the display never tears. A programmable blanking interval at each digit switch suppresses ghosting.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit slot. Legal range 2..2^20.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off. Must be less than `REFRESH_DIV`; 0 means no blanking.
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `hex_value`  in  16: four hex nibbles. `[3:0]` is digit 0, the rightmost digit.
- `dp_en`  in  4: decimal-point enable per digit.
- `seg_n`  out  7: segment drive, active low. Bit 0 = a, bit 6 = g.
- `dp_n`  out  1: decimal-point drive, active low.
- `digit_an_n`  out  4: anode select, active low, one-hot or all-off. Bit i = digit i.
- `frame_tick`  out  1: one-cycle pulse at the start of each frame.

## Operation
- Counters:
  - `slot_cnt` counts 0..`REFRESH_DIV`-1.
  - `digit` counts 0..3.
  - When `slot_cnt` wraps, `digit` increments and wraps 3→0.
- Two states per slot:
  - BLANK while `slot_cnt` < `BLANK_CYCLES`.
  - ACTIVE for the rest of the slot.
- BLANK outputs: `digit_an_n` = 4'b1111, `seg_n` = 7'h7F, `dp_n` = 1.
- ACTIVE outputs:
  - `digit_an_n` drives only bit `digit` low.
  - `seg_n` = decode of shadow nibble `digit`.
  - `dp_n` = ~shadow dp bit `digit`.
- Shadow load: the shadow registers capture `hex_value` and `dp_en` on the edge where `digit` wraps 3→0. Input changes mid-frame have no visible effect until the next frame.
- `frame_tick` is high exactly in the cycle where `digit` = 0 and `slot_cnt` = 0, excluding the first such cycle after reset.
- Decode (`seg_n[6:0]`, g..a):
  - 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000
  - 4 = 7'b0011001, 5 = 7'b0010010, 6 = 7'b0000010, 7 = 7'b1111000
  - 8 = 7'b0000000, 9 = 7'b0010000, A = 7'b0001000, b = 7'b0000011
  - C = 7'b1000110, d = 7'b0100001, E = 7'b0000110, F = 7'b0001110
- Reset mid-operation: all state returns immediately to its reset values and scanning restarts at digit 0, slot_cnt 0.

## Timing
- All outputs are registered. Output values in a given cycle correspond to that cycle's `slot_cnt`, `digit` and shadow contents. There is no extra pipeline lag.
- Reset values:
  - `digit_an_n` = 4'b1111, `seg_n` = 7'h7F, `dp_n` = 1, `frame_tick` = 0.
  - `slot_cnt` = 0, `digit` = 0, shadow = 0.
- First frame after reset displays shadow = 0000. The first load occurs at the first 3→0 wrap, 4×`REFRESH_DIV` cycles after reset release.
- Frame period: 4×`REFRESH_DIV` cycles.
- Input-to-display latency: at most 4×`REFRESH_DIV` + `BLANK_CYCLES` cycles.
- With `BLANK_CYCLES` = 0, a digit is ACTIVE from `slot_cnt` = 0. Anodes switch directly from one digit to the next in a single edge, and no all-off cycle occurs.

## Configuration
- Macro: `HEX_DIGIT_SCANNER_LZB_EN` (leading-zero blanking).
- Defined: during ACTIVE, digit i (i = 3..1) is blanked when shadow nibble i and all higher nibbles are zero. Blanking means anode off, `seg_n` = 7'h7F, and `dp_n` = 1 regardless of the dp bit. Digit 0 is never blanked.
- Undefined: all four digits are always displayed, including leading zeros.

## Test plan
Bench parameters: `REFRESH_DIV` = 8, `BLANK_CYCLES` = 2.
- Reset: hold `reset_n` = 0 for 3 cycles → `digit_an_n` = 4'b1111, `seg_n` = 7'h7F, `dp_n` = 1, `frame_tick` = 0. Release → digit 0 anode low from cycle 2 of slot 0 showing 7'b1000000.
- Scan order: `hex_value` = 16'h1A3F, `dp_en` = 4'b0100, run 2 frames. Second frame must show:
  - digit 0 = 7'b0001110, digit 1 = 7'b0110000, digit 2 = 7'b0001000 with `dp_n` = 0, digit 3 = 7'b1111001.
  - Each digit ACTIVE for exactly 6 cycles, preceded by 2 all-off cycles.
- No tearing: change `hex_value` 16'h1111 → 16'h2222 while digit 1 is ACTIVE → remaining digits still show 1. All digits show 2 only after the next `frame_tick`. `frame_tick` period = 32 cycles.
- All 16 nibble values: cycle digit 0 through 0..F, one per frame → `seg_n` matches the decode list for each value.
- Leading-zero blanking, with `HEX_DIGIT_SCANNER_LZB_EN` defined, `hex_value` = 16'h0040:
  - digits 3 and 2 anodes stay off; digit 1 = 7'b0011001; digit 0 = 7'b1000000.
  - Same stimulus with macro undefined → digits 3 and 2 show 7'b1000000.
- Reset mid-frame: assert `reset_n` low during digit 2 ACTIVE → outputs go to reset values asynchronously, within the same cycle. After release, scanning restarts at digit 0 with shadow = 0.

Source files
------------

// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner: four-digit multiplexed seven-segment driver with per-frame shadow capture and
// per-slot anode blanking. Optional leading-zero blanking is enabled by defining HEX_DIGIT_SCANNER_LZB_EN.
module hex_digit_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] hex_value,
    input  logic [3:0]  dp_en,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  digit_an_n,
    output logic        frame_tick
);
    localparam int SW = $clog2(REFRESH_DIV);
    localparam logic [SW-1:0] LAST = SW'(REFRESH_DIV - 1);

    typedef enum logic {BLANK, ACTIVE} state_t;

    state_t        state, state_n;
    logic [SW-1:0] slot_cnt, slot_n;
    logic [1:0]    digit, digit_n;
    logic [15:0]   shadow_hex, hex_n;
    logic [3:0]    shadow_dp, dp_sn;
    logic          slot_wrap, lit, blank_lead, tick_n, dp_nx;
    logic [6:0]    seg_nx;
    logic [3:0]    an_nx;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // Next counters, shadow and state; outputs are computed from next values so the registered outputs line up with their own cycle
    always_comb begin
        slot_wrap = slot_cnt == LAST;
        slot_n    = slot_wrap ? '0 : slot_cnt + 1'b1;
        digit_n   = slot_wrap ? digit + 2'd1 : digit;
        hex_n     = (slot_wrap && digit == 2'd3) ? hex_value : shadow_hex;
        dp_sn     = (slot_wrap && digit == 2'd3) ? dp_en : shadow_dp;
        state_n   = (int'(slot_n) < BLANK_CYCLES) ? BLANK : ACTIVE;
`ifdef HEX_DIGIT_SCANNER_LZB_EN
        blank_lead = (digit_n == 2'd3 && hex_n[15:12] == 4'h0) ||
                     (digit_n == 2'd2 && hex_n[15:8] == 8'h00) ||
                     (digit_n == 2'd1 && hex_n[15:4] == 12'h000);
`else
        blank_lead = 1'b0;
`endif
        lit    = state_n == ACTIVE && !blank_lead;
        an_nx  = lit ? ~(4'b0001 << digit_n) : 4'b1111;
        seg_nx = lit ? decode(hex_n[{digit_n, 2'b00} +: 4]) : 7'h7F;
        dp_nx  = lit ? ~dp_sn[digit_n] : 1'b1;
        tick_n = slot_n == '0 && digit_n == 2'd0;
    end

    // Scan counters, frame shadow, slot state and registered drives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt   <= '0;
            digit      <= 2'd0;
            shadow_hex <= 16'h0000;
            shadow_dp  <= 4'h0;
            state      <= BLANK;
            digit_an_n <= 4'b1111;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            slot_cnt   <= slot_n;
            digit      <= digit_n;
            shadow_hex <= hex_n;
            shadow_dp  <= dp_sn;
            state      <= state_n;
            digit_an_n <= an_nx;
            seg_n      <= seg_nx;
            dp_n       <= dp_nx;
            frame_tick <= tick_n;
        end
    end
endmodule

// File: tb/tb_hex_digit_scanner.sv
// tb_hex_digit_scanner: randomized scoreboard bench for hex_digit_scanner against a cycle-position reference model
module tb_hex_digit_scanner;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * RD;
    localparam logic [12:0] RST_EXP = {4'b1111, 7'h7F, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] hex_value = 16'h0000;
    logic [3:0]  dp_en = 4'h0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  digit_an_n;
    logic        frame_tick;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int passed = 0;
    int total = 0;
    int e = 0;
    int m_hex = 0;
    int m_dp = 0;
    logic [12:0] exp_q [$];

    hex_digit_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset_n(reset_n), .hex_value(hex_value), .dp_en(dp_en),
        .seg_n(seg_n), .dp_n(dp_n), .digit_an_n(digit_an_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: position in the frame is edges since reset release modulo the frame length
    always @(posedge clk) begin
        int p, d, s, nib;
        logic lit;
        logic [3:0] an;
        if (!reset_n) begin
            e = 0;
            m_hex = 0;
            m_dp = 0;
            exp_q.push_back(RST_EXP);
        end else begin
            e = e + 1;
            p = e % FRAME;
            if (p == 0) begin
                m_hex = int'(hex_value);
                m_dp = int'(dp_en);
            end
            d = p / RD;
            s = p % RD;
            nib = (m_hex >> (4 * d)) % 16;
            lit = s >= BC;
`ifdef HEX_DIGIT_SCANNER_LZB_EN
            if (d > 0 && (m_hex >> (4 * d)) == 0) lit = 1'b0;
`endif
            an = 4'b1111;
            if (lit) an[d] = 1'b0;
            exp_q.push_back({an, lit ? seg_tab[nib] : 7'h7F, lit ? !((m_dp >> d) % 2 == 1) : 1'b1, p == 0});
        end
    end

    // Monitor: compare every presented output against the oldest expectation
    always @(posedge clk) begin
        logic [12:0] got, want;
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = {digit_an_n, seg_n, dp_n, frame_tick};
            total++;
            if (got === want) passed++;
            else $display("FAIL scan e=%0d an/seg/dp/tick got %b_%b_%b_%b want %b_%b_%b_%b", e,
                          got[12:9], got[8:2], got[1], got[0], want[12:9], want[8:2], want[1], want[0]);
        end
    end

    task automatic wait_pos(input int p);
        int n = 0;
        while (e % FRAME != p && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME) begin
            total++;
            $display("FAIL wait_pos got pos %0d want %0d", e % FRAME, p);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    initial begin
        logic [12:0] got;
        hex_value = 16'h1A3F;
        dp_en = 4'b0100;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        frames(2);
        wait_pos(1);
        hex_value = 16'h1111;
        frames(1);
        wait_pos(RD + BC + 1);
        hex_value = 16'h2222;
        frames(2);
        for (int v = 0; v < 16; v++) begin
            wait_pos(3);
            hex_value = {4'(v + 1), 8'($urandom), 4'(v)};
            dp_en = 4'($urandom);
            frames(1);
        end
        for (int k = 0; k < 8; k++) begin
            wait_pos(int'($urandom_range(0, FRAME - 1)));
            hex_value = 16'($urandom);
            if (k % 3 == 0) hex_value = hex_value >> (4 * (k % 4));
            dp_en = 4'($urandom);
            frames(1);
        end
        for (int k = 0; k < 4; k++) begin
            wait_pos(5);
            hex_value = (k == 0) ? 16'h0040 : (k == 1) ? 16'h0000 : (k == 2) ? 16'h0005 : 16'h0300;
            dp_en = 4'b1111;
            frames(2);
        end
        hex_value = 16'h9876;
        frames(1);
        wait_pos(2 * RD + BC + 2);
        reset_n = 1'b0;
        #1;
        got = {digit_an_n, seg_n, dp_n, frame_tick};
        total++;
        if (got === RST_EXP) passed++;
        else $display("FAIL async_reset got %b want %b", got, RST_EXP);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        frames(3);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
